// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mdu_op_e    : op encoding on the op port (11x are no-ops)
//   mdu_state_e : control FSM states
//   DIV0_LO     : LO value written on divide by zero (sliced to WIDTH)
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101,
        MDU_NOP   = 3'b110
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } mdu_state_e;

    localparam int              MDU_MAX_W = 64;
    localparam logic [MDU_MAX_W-1:0] DIV0_LO = '1;

    // MULT and DIV work on magnitudes and restore signs afterwards
    function automatic logic op_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Shift-add multiplier / restoring divider datapath.
//   load      : capture op, operand magnitudes and sign flags, counter = WIDTH
//   step      : one multiply or divide iteration, counter decrements
//   last      : counter is 1, i.e. the current step is the final one
//   res_hi/lo : sign-corrected result, meaningful in the FIX cycle
//   res_dz    : latched divide-by-zero flag
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_dz
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH:0]   acc;    // product, or {remainder, quotient} with guard bit
    logic [WIDTH-1:0]   dvs;    // multiplicand / divisor magnitude
    logic [CW-1:0]      cnt;
    logic               is_div, neg_a, neg_b, dz;

    logic               sgn;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH:0]     madd;
    logic [2*WIDTH:0]   mul_nxt, sh, div_nxt;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    assign sgn = op_signed(op);
    assign ma  = (sgn && a[WIDTH-1]) ? -a : a;
    assign mb  = (sgn && b[WIDTH-1]) ? -b : b;

    // multiply: add multiplicand into upper half when LSB set, then shift right
    assign madd    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    assign mul_nxt = {1'b0, madd, acc[WIDTH-1:1]};

    // divide: shift left, trial-subtract divisor from upper part, keep if non-negative
    assign sh      = {acc[2*WIDTH-1:0], 1'b0};
    assign diff    = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, dvs};
    assign div_nxt = diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            dz     <= 1'b0;
        end else if (load) begin
            acc    <= {{(WIDTH+1){1'b0}}, ma};
            dvs    <= mb;
            cnt    <= CW'(WIDTH);
            is_div <= op[1];
            neg_a  <= sgn & a[WIDTH-1];
            neg_b  <= sgn & b[WIDTH-1];
            dz     <= op[1] && (b == '0);
        end else if (step) begin
            acc <= is_div ? div_nxt : mul_nxt;
            cnt <= cnt - CW'(1);
        end
    end

    assign last   = (cnt == CW'(1));
    assign res_dz = dz;

    // Sign flags are only ever set for signed ops, so no extra qualification.
    // With b = 0 the divider leaves |a| as remainder; giving it the dividend's
    // sign reproduces a exactly, including the most negative value.
    assign prod = (neg_a ^ neg_b) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign quot = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = rem;
            res_lo = dz ? DIV0_LO[WIDTH-1:0] : quot;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst          : clock, async active-high reset
//   start, op, a, b   : request (taken only in IDLE), operands sampled on accept
//   flush             : abort, no HI/LO write and no done
//   busy              : CALC/FIX in progress
//   done, div_by_zero : one-cycle completion pulse, divide-by-zero flag with it
//   hi, lo            : architectural registers
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e       state, nxt;
    logic             load, step, wr_res, wr_hi, wr_lo, last, res_dz;
    logic [WIDTH-1:0] res_hi, res_lo;

    mdu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .op     (op),
        .a      (a),
        .b      (b),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .res_dz (res_dz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        load   = 1'b0;
        step   = 1'b0;
        wr_res = 1'b0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        case (state)
            S_IDLE: begin
                // flush beats a simultaneous start
                if (start && !flush) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            load = 1'b1;
                            nxt  = S_CALC;
                        end
                        MDU_MTHI: begin
                            wr_hi = 1'b1;
                            nxt   = S_DONE;
                        end
                        MDU_MTLO: begin
                            wr_lo = 1'b1;
                            nxt   = S_DONE;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (flush) nxt = S_IDLE;
                else begin
                    step = 1'b1;
                    if (last) nxt = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) nxt = S_IDLE;
                else begin
                    wr_res = 1'b1;
                    nxt    = S_DONE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= wr_res & res_dz;
            if (wr_res) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b110;
    logic [W-1:0]  a = '0, b = '0;
    logic          flush = 1'b0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Arithmetic straight from 64-bit integer math; timing as "cycles since accept".
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, y,
                                   output logic [W-1:0] h, l, output bit d);
        longint     sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        d = 0;
        p = '0;
        h = '0;
        l = '0;
        case (o)
            3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
            default: begin
                if (y == 0) begin d = 1; h = x; l = '1; end
                else if (o == 3'd2) begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
                else begin h = x % y; l = x / y; end
            end
        endcase
    endfunction

    int           age = -1;   // cycle number of the running long op, -1 when none
    bit           m_done = 0, m_dz = 0, p_dz = 0, was_done;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age = -1; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
        end else begin
            was_done = m_done;
            m_done = 0;
            m_dz = 0;
            if (age >= 1) begin
                if (flush) age = -1;
                else if (age == W + 1) begin
                    m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1; age = -1;
                end else age++;
            end else if (!was_done && start && !flush) begin
                if (op < 3'd4) begin ref_op(op, a, b, p_hi, p_lo, p_dz); age = 1; end
                else if (op == 3'd4) begin m_hi = a; m_done = 1; end
                else if (op == 3'd5) begin m_lo = a; m_done = 1; end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (busy !== (age >= 1) || done !== m_done || div_by_zero !== m_dz ||
                hi !== m_hi || lo !== m_lo) begin
                errors++;
                $display("FAIL model t=%0t: got busy=%b done=%b dz=%b hi=%h lo=%h, want busy=%b done=%b dz=%b hi=%h lo=%h",
                         $time, busy, done, div_by_zero, hi, lo, age >= 1, m_done, m_dz, m_hi, m_lo);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic chk(input string name, input logic [W-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic stp();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller in cycle 1 (just after the accept edge); operands scrambled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, y);
        stp();
        start = 1'b1; op = o; a = x; b = y;
        stp();
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin stp(); cyc++; end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic preset();
        int c;
        issue(3'd4, 32'h1111_1111, 0); wait_done(c);
        issue(3'd5, 32'h2222_2222, 0); wait_done(c);
    endtask

    initial begin
        int c, n, k;
        logic [2:0] o;
        logic [W-1:0] x, y;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
        chk("rst_busy", W'(busy), 0); chk("rst_done", W'(done), 0);
        rst = 1'b0;

        issue(3'd4, 32'h1111_1111, 0); wait_done(c);
        chk("mthi_lat", c, 1); chk("mthi_busy", W'(busy), 0);
        issue(3'd5, 32'h2222_2222, 0); wait_done(c);
        chk("preset_hi", hi, 32'h1111_1111); chk("preset_lo", lo, 32'h2222_2222);

        issue(3'd0, 32'hFFFF_FFFF, 2);
        chk("mult_busy1", W'(busy), 1);
        wait_done(c);
        chk("mult_lat", c, 34); chk("mult_busy34", W'(busy), 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFF, 2); wait_done(c);
        chk("multu_hi", hi, 32'h0000_0001); chk("multu_lo", lo, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 2); wait_done(c);
        chk("div_hi", hi, 32'hFFFF_FFFF); chk("div_lo", lo, 32'hFFFF_FFFD);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(c);
        chk("ovf_hi", hi, 0); chk("ovf_lo", lo, 32'h8000_0000);

        issue(3'd3, 7, 0); wait_done(c);
        chk("dz_lat", c, 34); chk("dz_flag", W'(div_by_zero), 1);
        chk("dz_hi", hi, 7); chk("dz_lo", lo, 32'hFFFF_FFFF);

        // flush mid-MULTU, with an MTHI attempted while busy
        preset();
        issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        stp(); stp();                               // cycle 3
        start = 1'b1; op = 3'd4; a = 5;
        repeat (7) stp();                           // cycle 10
        start = 1'b0; flush = 1'b1;
        stp();                                      // cycle 11
        flush = 1'b0;
        chk("flush_busy", W'(busy), 0);
        k = 0;
        repeat (40) begin stp(); if (done) k++; end
        chk("flush_nodone", k, 0);
        chk("flush_hi", hi, 32'h1111_1111); chk("flush_lo", lo, 32'h2222_2222);

        issue(3'd5, 9, 0);
        chk("mtlo_lo", lo, 9); chk("mtlo_hi", hi, 32'h1111_1111); chk("mtlo_done", W'(done), 1);

        // flush with start in IDLE drops the request
        stp();
        start = 1'b1; op = 3'd4; a = 32'hABCD; flush = 1'b1;
        stp();
        start = 1'b0; flush = 1'b0;
        chk("fs_done", W'(done), 0); chk("fs_hi", hi, 32'h1111_1111);

        // randomized ops, some flushed at random points
        for (n = 0; n < 150; n++) begin
            o = 3'($urandom_range(0, 7)); x = pick(); y = pick();
            if (o < 3'd4 && $urandom_range(0, 5) == 0) begin
                issue(o, x, y);
                k = $urandom_range(0, W + 2);
                repeat (k) stp();
                flush = 1'b1; stp(); flush = 1'b0;
                repeat (W + 4) stp();
            end else if (o >= 3'd6) begin
                issue(o, x, y);
                repeat (2) stp();
            end else begin
                issue(o, x, y); wait_done(c);
                chk("rand_lat", c, (o < 3'd4) ? W + 2 : 1);
            end
        end

        // reset in the middle of a DIV
        preset();
        issue(3'd2, 100, 3);
        repeat (19) stp();                          // cycle 20
        rst = 1'b1;
        #1;
        chk("mrst_hi", hi, 0); chk("mrst_lo", lo, 0); chk("mrst_busy", W'(busy), 0);
        #2 rst = 1'b0;
        k = 0;
        repeat (40) begin stp(); if (done) k++; end
        chk("mrst_nodone", k, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want finish before 500000");
        $fatal(1);
    end

endmodule
